// File: rtl/clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_pkg
// Shared types, limits and the configuration clamp for the multi-channel
// programmable clock divider.
//   DEFAULT_WIDTH : default ratio/high counter width of a channel
//   CFG_W         : storage width of a configuration field (widest supported)
//   MIN_RATIO     : smallest legal period in input clock cycles
//   MIN_HIGH      : smallest legal high time in input clock cycles
//   div_cfg_t     : {ratio, high} pair held in the shadow and active registers
//   clamp_t       : clamp result, the legalised config plus an error flag
//   clamp_cfg()   : legalises a raw config before it becomes active
// -----------------------------------------------------------------------------
package clock_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Configuration fields are stored at this width. Channels narrower than
  // this zero-extend their inputs, which cannot overflow because the counter
  // never runs past ratio-1.
  localparam int CFG_W = 32;

  localparam logic [CFG_W-1:0] MIN_RATIO = CFG_W'(2);
  localparam logic [CFG_W-1:0] MIN_HIGH  = CFG_W'(1);

  typedef struct packed {
    logic [CFG_W-1:0] ratio;
    logic [CFG_W-1:0] high;
  } div_cfg_t;

  typedef struct packed {
    div_cfg_t cfg;
    logic     err;
  } clamp_t;

  // Configuration used after reset for both shadow and active registers.
  localparam div_cfg_t RESET_CFG = '{ratio: MIN_RATIO, high: MIN_HIGH};

  // The ratio is fixed first, so the high-time limit is checked against the
  // legal period rather than the raw one. A raw ratio of 0 therefore never
  // produces ratio-1 wrap-around downstream.
  function automatic clamp_t clamp_cfg(input div_cfg_t raw);
    clamp_t res;
    res.cfg = raw;
    res.err = 1'b0;
    if (raw.ratio < MIN_RATIO) begin
      res.cfg.ratio = MIN_RATIO;
      res.err       = 1'b1;
    end
    if (raw.high < MIN_HIGH) begin
      res.cfg.high = MIN_HIGH;
      res.err      = 1'b1;
    end
    if (res.cfg.high >= res.cfg.ratio) begin
      res.cfg.high = res.cfg.ratio - CFG_W'(1);
      res.err      = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// -----------------------------------------------------------------------------
// clock_divider_channel
// One independent divider channel: period counter, shadow and active
// configuration, pending flag and registered outputs.
//   clk      in   fast input clock, all logic on posedge
//   rst_n    in   asynchronous active-low reset
//   enable   in   run enable for this channel
//   load     in   strobe: capture ratio/high into the shadow register
//   ratio    in   WIDTH  period in clk cycles
//   high     in   WIDTH  clk_out high time in clk cycles
//   sync_all in   restart this channel at a period start (only while enabled)
//   clk_out  out  divided clock, registered
//   tick     out  one-cycle pulse on the first cycle of every period
//   pending  out  shadow holds a config that has not yet been applied
//   cfg_err  out  sticky: the last applied config needed clamping
//
// Load strobe: load is a single-cycle capture with no back-pressure. Every
// cycle it is high, the slice is written into the shadow (last write wins)
// and pending is set; the shadow reaches the active config only at a period
// boundary, which keeps the output free of runt pulses.
// -----------------------------------------------------------------------------
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] ratio,
  input  logic [WIDTH-1:0] high,
  input  logic             sync_all,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic             cfg_err
);

  logic [CFG_W-1:0] counter;
  logic [CFG_W-1:0] next_count;
  div_cfg_t         shadow;
  div_cfg_t         active;
  div_cfg_t         load_cfg;
  clamp_t           applied;

  // Remembers that enable was sampled high on the previous edge, so the
  // first enabled edge (after a disable or a reset) can be recognised.
  logic running;

  logic start;
  logic period_end;
  logic boundary;
  logic apply;

  always_comb begin
    load_cfg.ratio = CFG_W'(ratio);
    load_cfg.high  = CFG_W'(high);
  end

  // active.ratio is always >= MIN_RATIO, so ratio-1 cannot wrap.
  assign start      = enable & ~running;
  assign period_end = (counter == active.ratio - CFG_W'(1));
  assign boundary   = enable & (start | period_end | sync_all);
  assign apply      = boundary & (pending | start);
  assign next_count = counter + CFG_W'(1);
  assign applied    = clamp_cfg(shadow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      running <= 1'b0;
      shadow  <= RESET_CFG;
      active  <= RESET_CFG;
      pending <= 1'b0;
      cfg_err <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      running <= enable;

      if (!enable) begin
        counter <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (boundary) begin
        counter <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b1;
        if (apply) begin
          active  <= applied.cfg;
          cfg_err <= applied.err;
        end
      end else begin
        counter <= next_count;
        tick    <= 1'b0;
        // Output reflects the counter value being entered on this edge.
        clk_out <= (next_count < active.high);
      end

      // A load coinciding with a boundary wins over the clear: the boundary
      // has just consumed the old shadow, the new slice waits for the next one.
      if (load) begin
        shadow  <= load_cfg;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
// Multi-channel programmable clock divider. Each channel has a runtime ratio
// and high time that take effect only at a period boundary, plus a
// period-start tick. Channels are fully independent apart from syncAll.
//   clkIn    in   1               fast clock, all logic on posedge
//   reset    in   1               asynchronous active-low reset
//   enable   in   CHANNELS        per-channel run enable
//   load     in   CHANNELS        per-channel shadow capture strobe
//   ratio    in   CHANNELS*WIDTH  period, channel i = [i*WIDTH +: WIDTH]
//   high     in   CHANNELS*WIDTH  high time, same slicing
//   syncAll  in   1               restart every enabled channel
//   clkOut   out  CHANNELS        divided outputs, registered
//   tick     out  CHANNELS        first-cycle-of-period pulses
//   pending  out  CHANNELS        shadow captured, not yet applied
//   cfgErr   out  CHANNELS        sticky clamp indication
// -----------------------------------------------------------------------------
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic                      clkIn,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] ratio,
  input  logic [CHANNELS*WIDTH-1:0] high,
  input  logic                      syncAll,
  output logic [CHANNELS-1:0]       clkOut,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       cfgErr
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_divider_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk      (clkIn),
      .rst_n    (reset),
      .enable   (enable[i]),
      .load     (load[i]),
      .ratio    (ratio[i*WIDTH +: WIDTH]),
      .high     (high[i*WIDTH +: WIDTH]),
      .sync_all (syncAll),
      .clk_out  (clkOut[i]),
      .tick     (tick[i]),
      .pending  (pending[i]),
      .cfg_err  (cfgErr[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
// Directed bench for clock_divider_multi: a table of configurations on
// channel 0 with hand-computed legalised ratio/high/error, followed by
// hand-written sequences for deferred loads, load-at-boundary, syncAll
// alignment and mid-period reset.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;

  localparam int CH = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   load;
  logic [CH*W-1:0] ratio;
  logic [CH*W-1:0] high;
  logic            sync_all;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;
  logic [CH-1:0]   cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  clock_divider_multi #(
    .CHANNELS (CH),
    .WIDTH    (W)
  ) dut (
    .clkIn   (clk),
    .reset   (rst_n),
    .enable  (enable),
    .load    (load),
    .ratio   (ratio),
    .high    (high),
    .syncAll (sync_all),
    .clkOut  (clk_out),
    .tick    (tick),
    .pending (pending),
    .cfgErr  (cfg_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {tick, clk_out} k edges after a period start.
  function automatic logic [1:0] exp_out(input int k, input int r, input int h);
    int p;
    p = k % r;
    return {p == 0, p < h};
  endfunction

  task automatic set_cfg(input int ch, input int r, input int h);
    ratio[ch*W +: W] = W'(r);
    high[ch*W +: W]  = W'(h);
  endtask

  task automatic do_load(input int ch, input int r, input int h);
    set_cfg(ch, r, h);
    load[ch] = 1'b1;
    step();
    load[ch] = 1'b0;
  endtask

  task automatic check_ch0(input string name, input logic [1:0] exp);
    check(name, 32'({tick[0], clk_out[0]}), 32'(exp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int   r;
    int   h;
    int   exp_r;
    int   exp_h;
    logic exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] e0;
    logic [1:0] e1;

    vecs[0] = '{r: 10, h: 5, exp_r: 10, exp_h: 5, exp_err: 1'b0};
    vecs[1] = '{r: 7,  h: 2, exp_r: 7,  exp_h: 2, exp_err: 1'b0};
    vecs[2] = '{r: 0,  h: 0, exp_r: 2,  exp_h: 1, exp_err: 1'b1};
    vecs[3] = '{r: 8,  h: 9, exp_r: 8,  exp_h: 7, exp_err: 1'b1};
    vecs[4] = '{r: 8,  h: 4, exp_r: 8,  exp_h: 4, exp_err: 1'b0};
    vecs[5] = '{r: 1,  h: 1, exp_r: 2,  exp_h: 1, exp_err: 1'b1};
    vecs[6] = '{r: 5,  h: 5, exp_r: 5,  exp_h: 4, exp_err: 1'b1};
    vecs[7] = '{r: 3,  h: 1, exp_r: 3,  exp_h: 1, exp_err: 1'b0};

    // ---------------- reset ----------------
    rst_n    = 1'b0;
    enable   = '0;
    load     = '0;
    ratio    = '0;
    high     = '0;
    sync_all = 1'b0;
    #12;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- table: steady-state waveform per config ----------------
    foreach (vecs[v]) begin
      enable = '0;
      step();
      check("dis_clk_out", 32'(clk_out[0]), 32'd0);
      do_load(0, vecs[v].r, vecs[v].h);
      check("tbl_pending_set", 32'(pending[0]), 32'd1);
      enable[0] = 1'b1;
      step();
      check_ch0("tbl_first_edge", 2'b11);
      check("tbl_pending_clr", 32'(pending[0]), 32'd0);
      check("tbl_cfg_err", 32'(cfg_err[0]), 32'(vecs[v].exp_err));
      for (int k = 1; k <= 2 * vecs[v].exp_r; k++) begin
        step();
        check_ch0($sformatf("tbl%0d_k%0d", v, k), exp_out(k, vecs[v].exp_r, vecs[v].exp_h));
      end
    end

    // ---------------- deferred load: 7/2 then 4/2 ----------------
    enable = '0;
    step();
    do_load(0, 7, 2);
    enable[0] = 1'b1;
    step();
    check_ch0("defer_k0", 2'b11);
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) begin
        set_cfg(0, 4, 2);
        load[0] = 1'b1;
      end
      step();
      load[0] = 1'b0;
      e0 = (k < 7) ? exp_out(k, 7, 2) : exp_out(k - 7, 4, 2);
      check_ch0($sformatf("defer_k%0d", k), e0);
      check($sformatf("defer_pend_k%0d", k), 32'(pending[0]), 32'((k >= 4) && (k < 7)));
    end

    // ---------------- load on the period-end edge ----------------
    // 4/2 running; 5/1 loaded mid-period; 6/3 loaded on the edge that ends
    // the period. That boundary applies 5/1, the next one applies 6/3.
    enable = '0;
    step();
    do_load(0, 4, 2);
    enable[0] = 1'b1;
    step();
    check_ch0("lab_k0", 2'b11);
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) begin
        set_cfg(0, 5, 1);
        load[0] = 1'b1;
      end
      if (k == 4) begin
        set_cfg(0, 6, 3);
        load[0] = 1'b1;
      end
      step();
      load[0] = 1'b0;
      if (k < 4)      e0 = exp_out(k, 4, 2);
      else if (k < 9) e0 = exp_out(k - 4, 5, 1);
      else            e0 = exp_out(k - 9, 6, 3);
      check_ch0($sformatf("lab_k%0d", k), e0);
      check($sformatf("lab_pend_k%0d", k), 32'(pending[0]), 32'((k >= 2) && (k < 9)));
    end

    // ---------------- syncAll aligns ch0/ch1, ch2 stays idle ----------------
    enable = '0;
    step();
    do_load(0, 6, 3);
    do_load(1, 9, 4);
    enable = 4'b0001;
    step();                 // ch0 period start
    step();
    enable = 4'b0011;
    step();                 // ch1 period start, ch0 at 2
    step();
    step();                 // ch0 at 4, ch1 at 2
    check("presync_tick", 32'(tick), 32'd0);
    check("presync_clk",  32'(clk_out), 32'({2'b00, 1'b1, 1'b0}));
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    check("sync_tick", 32'(tick),    32'(4'b0011));
    check("sync_clk",  32'(clk_out), 32'(4'b0011));
    for (int k = 1; k <= 10; k++) begin
      step();
      e0 = exp_out(k, 6, 3);
      e1 = exp_out(k, 9, 4);
      check($sformatf("sync_tick_k%0d", k), 32'(tick),    32'({2'b00, e1[1], e0[1]}));
      check($sformatf("sync_clk_k%0d", k),  32'(clk_out), 32'({2'b00, e1[0], e0[0]}));
    end

    // ---------------- reset mid-period ----------------
    enable = '0;
    step();
    do_load(0, 0, 0);
    enable[0] = 1'b1;
    step();
    step();
    do_load(0, 5, 2);
    check("prerst_pending", 32'(pending[0]), 32'd1);
    check("prerst_cfg_err", 32'(cfg_err[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_clk_out", 32'(clk_out), 32'd0);
    check("mrst_tick",    32'(tick),    32'd0);
    check("mrst_pending", 32'(pending), 32'd0);
    check("mrst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #2;
    check("mrst_hold_clk", 32'(clk_out), 32'd0);
    rst_n = 1'b1;
    step();
    check_ch0("postrst_k0", 2'b11);
    check("postrst_cfg_err", 32'(cfg_err[0]), 32'd0);
    check("postrst_pending", 32'(pending[0]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_ch0($sformatf("postrst_k%0d", k), exp_out(k, 2, 1));
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
